memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Initiator-side controller for the single-port scratch memory. Accepts independent requests from one writer and two readers (A and B) and arbitrates them round-robin. It drives the memory's mutually exclusive write / read-to-a / read-to-b command pins and captures returned read data into per-reader holding registers with a valid pulse. It sits between the datapath clients and the memory instance, and guarantees that at most one command pin is asserted in any cycle.

## Interface
- DATA_WIDTH, 8, width of data words
- ADDR_WIDTH, 10, width of addresses
- MEM_SIZE, 10, highest legal address (memory holds MEM_SIZE+1 words)

- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- iWrReq  in  1  write request, held until oWrGnt
- iWrAddr  in  ADDR_WIDTH  write address
- iWrData  in  DATA_WIDTH  write data
- oWrGnt  out  1  write granted this cycle
- iRdReqA / iRdReqB  in  1  read request per reader, held until grant
- iRdAddrA / iRdAddrB  in  ADDR_WIDTH  read address per reader
- oRdGntA / oRdGntB  out  1  read granted this cycle
- oRdValidA / oRdValidB  out  1  one-cycle pulse: holding register updated
- oRdDataA / oRdDataB  out  DATA_WIDTH  last read word per reader, held until next valid
- oAddrErr  out  1  one-cycle pulse: granted request had address > MEM_SIZE
- oMemWriteEnable, oMemReadtoa, oMemReadtob  out  1 each  memory command, at most one high
- oMemAddress  out  ADDR_WIDTH  memory address
- oMemDataIn  out  DATA_WIDTH  memory write data
- iMemDataOuta / iMemDataOutb  in  DATA_WIDTH  memory read ports; valid only in the cycle after the memory samples a read command

## Operation
- Grants are combinational from requests and the priority pointer. At most one grant per cycle.
- Round-robin order is W → A → B → W. After a grant to X, X's successor gets highest priority. Reset priority: W > A > B.
- The pointer advances on every grant, including error grants. It holds when there is no request.
- A granted request with address ≤ MEM_SIZE is registered into the command stage: exactly one oMem* command bit, plus address and data (data only for writes; otherwise zero).
- A granted request with address > MEM_SIZE produces no memory command (idle). oAddrErr pulses the next cycle. A rejected read produces no oRdValid.
- Read tracking: a 2-stage tag pipeline (none/A/B) follows each issued read. At the capture stage, the tagged holding register loads from the matching iMemDataOut port. The other holding register is unchanged.
- Idle cycles drive all command bits low, address 0 and data 0.
- A requester that keeps its request high after a grant is treated as issuing a new request and competes again the next cycle.
- Reset (asynchronous, any time):
  - all oMem* outputs, grants, valids and oAddrErr go to 0;
  - both holding registers go to 0;
  - the pointer returns to W;
  - in-flight reads are discarded and never produce valid.

## Timing
- Cycle N: grant asserted, request sampled at the end of N.
- N+1: command on the oMem* pins. The memory samples it at the end of N+1. oAddrErr is driven in N+1 for error grants.
- N+2: read data is present on iMemDataOut; the arbiter captures it at the end of N+2.
- N+3: oRdValidX high for one cycle, with oRdDataX holding the new value.
- Read latency is 3 cycles from grant to valid. A write takes effect in memory at the end of N+1.
- Throughput is one command per cycle. Back-to-back reads to the same reader give consecutive valid pulses.
- A write issued the cycle after a read to the same address does not affect that read's data (the read samples first).

## Structure
- Package mem_ctrl_pkg holds:
  - the command encoding constants (CMD_IDLE, CMD_WR, CMD_RDA, CMD_RDB);
  - the read-tag encoding (TAG_NONE, TAG_A, TAG_B);
  - the requester index constants used by the pointer.
- Sub-module rr_arbiter3 contains the 3-way round-robin grant logic and its pointer register (Clock, Reset_n, 3-bit req, 3-bit one-hot gnt).
- memory_arbiter contains the command register, address check, tag pipeline and holding registers.

## Test plan
- Single write then read: write W addr 3 data 0xA5, then A read addr 3. Required: oMemWriteEnable high for one cycle, then oRdValidA exactly 3 cycles after oRdGntA, with oRdDataA = 0xA5 and oRdDataB unchanged (0).
- Three-way contention: W, A and B all request continuously from reset. Required: grants in order W, A, B, W, A, B, never two oMem* command bits high, and the valids for A and B arrive in grant order.
- Boundary address: A reads addr MEM_SIZE (10) → valid data. B reads addr 11 → oAddrErr pulses 1 cycle after the grant, no command issued, no oRdValidB.
- Read-B isolation: B reads addr 5 (preloaded with 0x3C) while oRdDataA holds 0x11. Required: oRdValidB with 0x3C, oRdDataA still 0x11, no oRdValidA.
- Reset mid-read: assert Reset_n low in the cycle after the grant of an A read. Required: outputs go to 0 immediately, no oRdValidA after release, and the first post-reset contention grants W first.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the scratch-memory arbiter: command codes, read tags,
// requester indices and the command-to-pin decode.
package mem_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned MEM_SIZE_DEF   = 10;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned REQ_W   = 0;
    localparam int unsigned REQ_A   = 1;
    localparam int unsigned REQ_B   = 2;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_WR   = 2'd1,
        CMD_RDA  = 2'd2,
        CMD_RDB  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_A    = 2'd1,
        TAG_B    = 2'd2
    } tag_e;

    // Pointer values name the requester that currently holds top priority.
    typedef enum logic [1:0] {
        PTR_W = 2'd0,
        PTR_A = 2'd1,
        PTR_B = 2'd2
    } ptr_e;

    typedef struct packed {
        logic we;
        logic rda;
        logic rdb;
    } mem_pins_t;

    function automatic mem_pins_t cmd_pins(input cmd_e cmd);
        mem_pins_t p;
        p = '{we: 1'b0, rda: 1'b0, rdb: 1'b0};
        case (cmd)
            CMD_WR:  p.we  = 1'b1;
            CMD_RDA: p.rda = 1'b1;
            CMD_RDB: p.rdb = 1'b1;
            default: p = '{we: 1'b0, rda: 1'b0, rdb: 1'b0};
        endcase
        return p;
    endfunction

    function automatic tag_e cmd_tag(input cmd_e cmd);
        tag_e t;
        case (cmd)
            CMD_RDA: t = TAG_A;
            CMD_RDB: t = TAG_B;
            default: t = TAG_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Client and memory-side signal bundle of the scratch-memory arbiter.
// slave is the arbiter's view, master is the surrounding clients/memory.
interface memory_arbiter_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  iWrReq;
    logic [ADDR_WIDTH-1:0] iWrAddr;
    logic [DATA_WIDTH-1:0] iWrData;
    logic                  oWrGnt;
    logic                  iRdReqA;
    logic                  iRdReqB;
    logic [ADDR_WIDTH-1:0] iRdAddrA;
    logic [ADDR_WIDTH-1:0] iRdAddrB;
    logic                  oRdGntA;
    logic                  oRdGntB;
    logic                  oRdValidA;
    logic                  oRdValidB;
    logic [DATA_WIDTH-1:0] oRdDataA;
    logic [DATA_WIDTH-1:0] oRdDataB;
    logic                  oAddrErr;
    logic                  oMemWriteEnable;
    logic                  oMemReadtoa;
    logic                  oMemReadtob;
    logic [ADDR_WIDTH-1:0] oMemAddress;
    logic [DATA_WIDTH-1:0] oMemDataIn;
    logic [DATA_WIDTH-1:0] iMemDataOuta;
    logic [DATA_WIDTH-1:0] iMemDataOutb;

    modport slave (
        input  iWrReq, iWrAddr, iWrData, iRdReqA, iRdReqB, iRdAddrA, iRdAddrB,
        input  iMemDataOuta, iMemDataOutb,
        output oWrGnt, oRdGntA, oRdGntB, oRdValidA, oRdValidB, oRdDataA, oRdDataB,
        output oAddrErr, oMemWriteEnable, oMemReadtoa, oMemReadtob, oMemAddress, oMemDataIn
    );

    modport master (
        output iWrReq, iWrAddr, iWrData, iRdReqA, iRdReqB, iRdAddrA, iRdAddrB,
        output iMemDataOuta, iMemDataOutb,
        input  oWrGnt, oRdGntA, oRdGntB, oRdValidA, oRdValidB, oRdDataA, oRdDataB,
        input  oAddrErr, oMemWriteEnable, oMemReadtoa, oMemReadtob, oMemAddress, oMemDataIn
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter (W -> A -> B -> W) with combinational grants
// and a priority pointer that moves to the successor of each grant.
module rr_arbiter3
    import mem_ctrl_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    ptr_e               ptr_r;
    ptr_e               ptr_nxt_s;
    logic [NUM_REQ-1:0] gnt_s;

    // Priority pointer register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_r <= PTR_W;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    // Grant selection in pointer order; pointer holds when nobody requests.
    always_comb begin
        gnt_s     = '0;
        ptr_nxt_s = ptr_r;
        case (ptr_r)
            PTR_W: begin
                if (req[REQ_W]) begin
                    gnt_s[REQ_W] = 1'b1; ptr_nxt_s = PTR_A;
                end else if (req[REQ_A]) begin
                    gnt_s[REQ_A] = 1'b1; ptr_nxt_s = PTR_B;
                end else if (req[REQ_B]) begin
                    gnt_s[REQ_B] = 1'b1; ptr_nxt_s = PTR_W;
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            PTR_A: begin
                if (req[REQ_A]) begin
                    gnt_s[REQ_A] = 1'b1; ptr_nxt_s = PTR_B;
                end else if (req[REQ_B]) begin
                    gnt_s[REQ_B] = 1'b1; ptr_nxt_s = PTR_W;
                end else if (req[REQ_W]) begin
                    gnt_s[REQ_W] = 1'b1; ptr_nxt_s = PTR_A;
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            PTR_B: begin
                if (req[REQ_B]) begin
                    gnt_s[REQ_B] = 1'b1; ptr_nxt_s = PTR_W;
                end else if (req[REQ_W]) begin
                    gnt_s[REQ_W] = 1'b1; ptr_nxt_s = PTR_A;
                end else if (req[REQ_A]) begin
                    gnt_s[REQ_A] = 1'b1; ptr_nxt_s = PTR_B;
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            default: begin
                gnt_s     = '0;
                ptr_nxt_s = PTR_W;
            end
        endcase
    end

    // Grants are suppressed while reset is asserted.
    assign gnt = Reset_n ? gnt_s : '0;

endmodule

// File: rtl/memory_arbiter.sv
// Initiator-side controller for the single-port scratch memory: arbitrates
// one writer and two readers, issues one command per cycle, returns read data.
module memory_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned MEM_SIZE   = MEM_SIZE_DEF
)
(
    input  logic             Clock,
    input  logic             Reset_n,
    memory_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0]    req_s;
    logic [NUM_REQ-1:0]    gnt_s;
    cmd_e                  cmd_sel_s;
    logic [ADDR_WIDTH-1:0] addr_sel_s;
    logic [DATA_WIDTH-1:0] data_sel_s;
    logic                  addr_ok_s;
    cmd_e                  cmd_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic [DATA_WIDTH-1:0] data_nxt_s;
    logic                  err_nxt_s;

    mem_pins_t             pins_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  err_r;
    tag_e                  tag0_r;
    tag_e                  tag1_r;
    logic [DATA_WIDTH-1:0] hold_a_r;
    logic [DATA_WIDTH-1:0] hold_b_r;
    logic                  valid_a_r;
    logic                  valid_b_r;

    assign req_s[REQ_W] = bus.iWrReq;
    assign req_s[REQ_A] = bus.iRdReqA;
    assign req_s[REQ_B] = bus.iRdReqB;

    rr_arbiter3 u_rr_arbiter3 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .req     (req_s),
        .gnt     (gnt_s)
    );

    assign bus.oWrGnt  = gnt_s[REQ_W];
    assign bus.oRdGntA = gnt_s[REQ_A];
    assign bus.oRdGntB = gnt_s[REQ_B];

    // Route the granted request and turn out-of-range addresses into idle plus error.
    always_comb begin
        cmd_sel_s  = CMD_IDLE;
        addr_sel_s = '0;
        data_sel_s = '0;
        if (gnt_s[REQ_W]) begin
            cmd_sel_s  = CMD_WR;
            addr_sel_s = bus.iWrAddr;
            data_sel_s = bus.iWrData;
        end else if (gnt_s[REQ_A]) begin
            cmd_sel_s  = CMD_RDA;
            addr_sel_s = bus.iRdAddrA;
        end else if (gnt_s[REQ_B]) begin
            cmd_sel_s  = CMD_RDB;
            addr_sel_s = bus.iRdAddrB;
        end else begin
            cmd_sel_s  = CMD_IDLE;
        end

        addr_ok_s  = (addr_sel_s <= ADDR_WIDTH'(MEM_SIZE));
        cmd_nxt_s  = CMD_IDLE;
        addr_nxt_s = '0;
        data_nxt_s = '0;
        err_nxt_s  = 1'b0;
        if (cmd_sel_s == CMD_IDLE) begin
            err_nxt_s = 1'b0;
        end else if (!addr_ok_s) begin
            err_nxt_s = 1'b1;
        end else begin
            cmd_nxt_s  = cmd_sel_s;
            addr_nxt_s = addr_sel_s;
            data_nxt_s = data_sel_s;
        end
    end

    // Command stage driving the memory pins and the error pulse.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pins_r <= '{we: 1'b0, rda: 1'b0, rdb: 1'b0};
            addr_r <= '0;
            data_r <= '0;
            err_r  <= 1'b0;
        end else begin
            pins_r <= cmd_pins(cmd_nxt_s);
            addr_r <= addr_nxt_s;
            data_r <= data_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    // Tag pipeline: tag0 aligns with the command, tag1 with returned data.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tag0_r <= TAG_NONE;
            tag1_r <= TAG_NONE;
        end else begin
            tag0_r <= cmd_tag(cmd_nxt_s);
            tag1_r <= tag0_r;
        end
    end

    // Holding registers load only from the port that matches the returning tag.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_a_r  <= '0;
            hold_b_r  <= '0;
            valid_a_r <= 1'b0;
            valid_b_r <= 1'b0;
        end else begin
            valid_a_r <= (tag1_r == TAG_A);
            valid_b_r <= (tag1_r == TAG_B);
            if (tag1_r == TAG_A) begin
                hold_a_r <= bus.iMemDataOuta;
            end
            if (tag1_r == TAG_B) begin
                hold_b_r <= bus.iMemDataOutb;
            end
        end
    end

    assign bus.oMemWriteEnable = pins_r.we;
    assign bus.oMemReadtoa     = pins_r.rda;
    assign bus.oMemReadtob     = pins_r.rdb;
    assign bus.oMemAddress     = addr_r;
    assign bus.oMemDataIn      = data_r;
    assign bus.oAddrErr        = err_r;
    assign bus.oRdValidA       = valid_a_r;
    assign bus.oRdValidB       = valid_b_r;
    assign bus.oRdDataA        = hold_a_r;
    assign bus.oRdDataB        = hold_b_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: memory model, reference contents,
// read scoreboard, a grant vector table and hand-written corner sequences.
module tb_memory_arbiter;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 10;
    localparam int unsigned MSZ = 10;

    logic Clock;
    logic Reset_n;

    memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MSZ)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Scratch memory model: reads sample before a same-edge write lands.
    logic [DW-1:0] mem [0:MSZ] = '{default: 8'h00};
    always @(posedge Clock) begin
        if (bus.oMemWriteEnable && bus.oMemAddress <= 10'd10)
            mem[bus.oMemAddress] <= bus.oMemDataIn;
        if (bus.oMemReadtoa && bus.oMemAddress <= 10'd10)
            bus.iMemDataOuta <= mem[bus.oMemAddress];
        if (bus.oMemReadtob && bus.oMemAddress <= 10'd10)
            bus.iMemDataOutb <= mem[bus.oMemAddress];
    end

    typedef struct {
        logic          is_b;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    typedef struct {
        logic [2:0]    req;   // {B, A, W}
        logic [AW-1:0] aw;
        logic [DW-1:0] dw;
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        logic [2:0]    gnt;   // {B, A, W}
    } vec_t;

    rd_t           rd_q[$];
    vec_t          vecs[12];
    logic [DW-1:0] ref_mem [0:MSZ];
    int            checks;
    int            errors;
    int            cyc;
    logic          exp_we, exp_ra, exp_rb, exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_hold_a, exp_hold_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_expect();
        rd_q.delete();
        exp_we = 1'b0; exp_ra = 1'b0; exp_rb = 1'b0; exp_err = 1'b0;
        exp_addr = '0; exp_data = '0;
        exp_hold_a = '0; exp_hold_b = '0;
    endtask

    // Called mid-cycle: checks registered outputs, then records this cycle's grant.
    task automatic monitor();
        logic [2:0]    g;
        logic          we_n, ra_n, rb_n, err_n, va, vb;
        logic [AW-1:0] a_n;
        logic [DW-1:0] d_n;
        rd_t           e;
        chk("cmd_we",   32'(bus.oMemWriteEnable), 32'(exp_we));
        chk("cmd_rda",  32'(bus.oMemReadtoa),     32'(exp_ra));
        chk("cmd_rdb",  32'(bus.oMemReadtob),     32'(exp_rb));
        chk("cmd_addr", 32'(bus.oMemAddress),     32'(exp_addr));
        chk("cmd_data", 32'(bus.oMemDataIn),      32'(exp_data));
        chk("addr_err", 32'(bus.oAddrErr),        32'(exp_err));
        chk("cmd_onehot0",
            32'($countones({bus.oMemWriteEnable, bus.oMemReadtoa, bus.oMemReadtob}) <= 1), 32'd1);
        va = 1'b0; vb = 1'b0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e = rd_q.pop_front();
            if (e.is_b) begin vb = 1'b1; exp_hold_b = e.data; end
            else        begin va = 1'b1; exp_hold_a = e.data; end
        end
        chk("valid_a", 32'(bus.oRdValidA), 32'(va));
        chk("valid_b", 32'(bus.oRdValidB), 32'(vb));
        chk("data_a",  32'(bus.oRdDataA),  32'(exp_hold_a));
        chk("data_b",  32'(bus.oRdDataB),  32'(exp_hold_b));

        g = {bus.oRdGntB, bus.oRdGntA, bus.oWrGnt};
        chk("gnt_onehot0", 32'($countones(g) <= 1), 32'd1);
        we_n = 1'b0; ra_n = 1'b0; rb_n = 1'b0; err_n = 1'b0; a_n = '0; d_n = '0;
        if (g[0]) begin
            if (bus.iWrAddr <= 10'd10) begin
                we_n = 1'b1; a_n = bus.iWrAddr; d_n = bus.iWrData;
                ref_mem[bus.iWrAddr] = bus.iWrData;
            end else err_n = 1'b1;
        end
        if (g[1]) begin
            if (bus.iRdAddrA <= 10'd10) begin
                ra_n = 1'b1; a_n = bus.iRdAddrA;
                rd_q.push_back('{1'b0, ref_mem[bus.iRdAddrA], cyc + 3});
            end else err_n = 1'b1;
        end
        if (g[2]) begin
            if (bus.iRdAddrB <= 10'd10) begin
                rb_n = 1'b1; a_n = bus.iRdAddrB;
                rd_q.push_back('{1'b1, ref_mem[bus.iRdAddrB], cyc + 3});
            end else err_n = 1'b1;
        end
        exp_we = we_n; exp_ra = ra_n; exp_rb = rb_n; exp_err = err_n;
        exp_addr = a_n; exp_data = d_n;
    endtask

    task automatic tick();
        @(negedge Clock);
        monitor();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Hold one request until granted (bounded), then drop it.
    task automatic issue(input int who, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic g;
        g = 1'b0;
        case (who)
            0: begin bus.iWrReq = 1'b1; bus.iWrAddr = addr; bus.iWrData = data; end
            1: begin bus.iRdReqA = 1'b1; bus.iRdAddrA = addr; end
            default: begin bus.iRdReqB = 1'b1; bus.iRdAddrB = addr; end
        endcase
        for (int k = 0; k < 8 && !g; k++) begin
            @(negedge Clock);
            g = (who == 0) ? bus.oWrGnt : (who == 1) ? bus.oRdGntA : bus.oRdGntB;
            monitor();
            @(posedge Clock);
            #1;
            cyc++;
        end
        bus.iWrReq = 1'b0; bus.iRdReqA = 1'b0; bus.iRdReqB = 1'b0;
        chk($sformatf("grant_wait_%0d", who), 32'(g), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i <= int'(MSZ); i++) ref_mem[i] = 8'h00;
        clear_expect();
        //            req     aw      dw      aa      ab      gnt
        vecs[0]  = '{3'b111, 10'd3,  8'h5A, 10'd3,  10'd10, 3'b001};
        vecs[1]  = '{3'b111, 10'd4,  8'h66, 10'd3,  10'd10, 3'b010};
        vecs[2]  = '{3'b111, 10'd4,  8'h66, 10'd3,  10'd10, 3'b100};
        vecs[3]  = '{3'b111, 10'd4,  8'h66, 10'd3,  10'd10, 3'b001};
        vecs[4]  = '{3'b000, 10'd0,  8'h00, 10'd0,  10'd0,  3'b000};
        vecs[5]  = '{3'b001, 10'd10, 8'hC3, 10'd0,  10'd0,  3'b001};
        vecs[6]  = '{3'b101, 10'd2,  8'h77, 10'd0,  10'd4,  3'b100};
        vecs[7]  = '{3'b110, 10'd0,  8'h00, 10'd10, 10'd3,  3'b010};
        vecs[8]  = '{3'b011, 10'd5,  8'h99, 10'd0,  10'd0,  3'b001};
        vecs[9]  = '{3'b100, 10'd0,  8'h00, 10'd0,  10'd11, 3'b100};
        vecs[10] = '{3'b010, 10'd0,  8'h00, 10'd1023, 10'd0, 3'b010};
        vecs[11] = '{3'b001, 10'd12, 8'h42, 10'd0,  10'd0,  3'b001};

        bus.iWrReq = 1'b0; bus.iWrAddr = '0; bus.iWrData = '0;
        bus.iRdReqA = 1'b0; bus.iRdReqB = 1'b0; bus.iRdAddrA = '0; bus.iRdAddrB = '0;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_pins", 32'({bus.oMemWriteEnable, bus.oMemReadtoa, bus.oMemReadtob}), 32'd0);
        chk("rst_addr", 32'(bus.oMemAddress), 32'd0);
        chk("rst_hold", 32'({bus.oRdDataA, bus.oRdDataB}), 32'd0);
        chk("rst_flags", 32'({bus.oRdValidA, bus.oRdValidB, bus.oAddrErr}), 32'd0);
        Reset_n = 1'b1;

        // Single write then read of the same word.
        issue(0, 10'd3, 8'hA5);
        issue(1, 10'd3, 8'h00);
        idle(4);
        chk("wr_rd_data_a", 32'(bus.oRdDataA), 32'hA5);
        chk("wr_rd_data_b", 32'(bus.oRdDataB), 32'h00);

        // Read-B isolation with A holding 0x11.
        issue(0, 10'd5, 8'h3C);
        issue(0, 10'd7, 8'h11);
        issue(1, 10'd7, 8'h00);
        idle(4);
        issue(2, 10'd5, 8'h00);
        idle(4);
        chk("iso_data_b", 32'(bus.oRdDataB), 32'h3C);
        chk("iso_data_a", 32'(bus.oRdDataA), 32'h11);

        // Boundary addresses: MEM_SIZE is legal, MEM_SIZE+1 is rejected.
        issue(0, 10'd10, 8'h7E);
        issue(1, 10'd10, 8'h00);
        issue(2, 10'd11, 8'h00);
        idle(4);
        chk("bnd_data_a", 32'(bus.oRdDataA), 32'h7E);
        chk("bnd_data_b", 32'(bus.oRdDataB), 32'h3C);

        // Read followed by a write to the same address keeps the old data.
        issue(1, 10'd3, 8'h00);
        issue(0, 10'd3, 8'hE1);
        idle(4);
        chk("rd_before_wr", 32'(bus.oRdDataA), 32'hA5);

        // Back-to-back reads to one reader.
        issue(1, 10'd7, 8'h00);
        issue(1, 10'd3, 8'h00);
        idle(5);

        // Reset in the cycle after an A read grant.
        issue(1, 10'd5, 8'h00);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_pins", 32'({bus.oMemWriteEnable, bus.oMemReadtoa, bus.oMemReadtob}), 32'd0);
        chk("mid_rst_hold", 32'({bus.oRdDataA, bus.oRdDataB}), 32'd0);
        chk("mid_rst_flags", 32'({bus.oRdValidA, bus.oRdValidB, bus.oAddrErr}), 32'd0);
        clear_expect();
        idle(2);
        Reset_n = 1'b1;
        idle(4);

        // Grant table from the reset pointer; first row is three-way contention.
        for (int i = 0; i < 12; i++) begin
            bus.iWrReq   = vecs[i].req[0];
            bus.iRdReqA  = vecs[i].req[1];
            bus.iRdReqB  = vecs[i].req[2];
            bus.iWrAddr  = vecs[i].aw;
            bus.iWrData  = vecs[i].dw;
            bus.iRdAddrA = vecs[i].aa;
            bus.iRdAddrB = vecs[i].ab;
            @(negedge Clock);
            chk($sformatf("vec%0d_gnt", i),
                32'({bus.oRdGntB, bus.oRdGntA, bus.oWrGnt}), 32'(vecs[i].gnt));
            monitor();
            @(posedge Clock);
            #1;
            cyc++;
        end
        bus.iWrReq = 1'b0; bus.iRdReqA = 1'b0; bus.iRdReqB = 1'b0;
        idle(5);
        chk("scoreboard_drained", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
